// File: rtl/calc_top.sv
// calc_top: four-function decimal keypad calculator with an eight-digit seven-segment display.
//
// Ports
//   clock     rising-edge system clock
//   reset     asynchronous, active-low reset
//   cmd       key code: 0-9 digit, 1010 add, 1011 sub, 1100 mul, 1101 clear, 1110 equals,
//             1111 backspace
//   displays  eight seven-segment digits (gfedcba, active-high), displays[0] least significant
//   status    00 ready, 01 busy (calculating), 10 error
//   EA        current FSM state
//   PE        next FSM state (combinational)
//
// Build option
//   CALC_BACKSPACE_EN  when defined, 1111 deletes the least-significant digit of the operand
//                      being entered; otherwise 1111 is ignored.
module calc_top (
  input  logic            clock,
  input  logic            reset,
  input  logic [3:0]      cmd,
  output logic [7:0][6:0] displays,
  output logic [1:0]      status,
  output logic [2:0]      EA,
  output logic [2:0]      PE
);

  typedef enum logic [2:0] {
    StWaitA  = 3'd0,
    StWaitB  = 3'd1,
    StCalc   = 3'd2,
    StResult = 3'd3,
    StError  = 3'd4
  } state_e;

  localparam logic [1:0]  OpAdd        = 2'd0;
  localparam logic [1:0]  OpSub        = 2'd1;
  localparam logic [1:0]  OpMul        = 2'd2;
  localparam logic [26:0] EightDigits  = 27'd10_000_000;
  localparam logic [26:0] MaxNegMag    = 27'd9_999_999;
  localparam logic [26:0] MaxPos       = 27'd99_999_999;
  localparam logic signed [29:0] AsMin = -30'sd9_999_999;
  localparam logic signed [29:0] AsMax = 30'sd99_999_999;
  // Multiplier operand is 27 bits wide, one bit consumed per cycle.
  localparam logic [4:0]  MulLastCycle = 5'd26;
  localparam logic [6:0]  SegMinus     = 7'b1000000;
  localparam logic [6:0]  SegE         = 7'b1111001;

  state_e             state_q, state_d;
  logic [3:0]         cmd_q;
  logic signed [27:0] a_q, a_d;       // A doubles as the result register
  logic [26:0]        b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic               b_ent_q, b_ent_d; // a B digit has been entered
  logic [53:0]        mcand_q, mcand_d;
  logic [53:0]        prod_q, prod_d;
  logic [26:0]        mplier_q, mplier_d;
  logic [4:0]         cnt_q, cnt_d;

  // Key decode: a key acts only on the cycle it differs from the previous sample.
  logic       key_new, is_digit, is_op, is_clear, is_eq;
  logic [1:0] op_key;

  assign key_new  = (cmd != cmd_q);
  assign is_digit = key_new && (cmd <= 4'd9);
  assign is_op    = key_new && (cmd >= 4'd10) && (cmd <= 4'd12);
  assign is_clear = key_new && (cmd == 4'd13);
  assign is_eq    = key_new && (cmd == 4'd14);
  assign op_key   = cmd[1:0] ^ 2'b10;

  // Operand editing; A is never negative while it is being typed.
  logic [26:0] a_mag, opnd, opnd_app;
  logic        digit_ok;

  assign a_mag    = a_q[27] ? (~a_q[26:0] + 27'd1) : a_q[26:0];
  assign opnd     = (state_q == StWaitB) ? b_q : a_q[26:0];
  assign opnd_app = opnd * 27'd10 + {23'd0, cmd};
  assign digit_ok = (opnd < EightDigits) && !((cmd == 4'd0) && (opnd == '0));

`ifdef CALC_BACKSPACE_EN
  logic        is_bksp;
  logic [26:0] opnd_bs;
  assign is_bksp = key_new && (cmd == 4'd15);
  assign opnd_bs = opnd / 27'd10;
`endif

  // Add/sub complete in a single cycle.
  logic signed [29:0] as_res;
  logic               as_ok;

  assign as_res = (op_q == OpSub) ? ({{2{a_q[27]}}, a_q} - {3'b000, b_q})
                                  : ({{2{a_q[27]}}, a_q} + {3'b000, b_q});
  assign as_ok  = (as_res >= AsMin) && (as_res <= AsMax);

  // Shift-add multiply on |A| * B; sign restored at the end.
  logic [53:0] prod_nx;
  logic        mul_neg, mul_ok;
  logic [27:0] mul_val;

  assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_neg = a_q[27] && (prod_nx != '0);
  assign mul_ok  = mul_neg ? (prod_nx <= {27'd0, MaxNegMag}) : (prod_nx <= {27'd0, MaxPos});
  assign mul_val = mul_neg ? (~{1'b0, prod_nx[26:0]} + 28'd1) : {1'b0, prod_nx[26:0]};

  logic        calc_done, calc_ok;
  logic [27:0] calc_val;

  assign calc_done = (op_q != OpMul) || (cnt_q == MulLastCycle);
  assign calc_ok   = (op_q == OpMul) ? mul_ok : as_ok;
  assign calc_val  = (op_q == OpMul) ? mul_val : as_res[27:0];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    b_ent_d  = b_ent_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    if (is_clear && (state_q != StCalc)) begin
      a_d     = '0;
      b_d     = '0;
      op_d    = OpAdd;
      b_ent_d = 1'b0;
      state_d = StWaitA;
    end else begin
      case (state_q)
        StWaitA: begin
          if (is_digit) begin
            if (digit_ok) a_d = {1'b0, opnd_app};
          end else if (is_op) begin
            op_d    = op_key;
            b_d     = '0;
            b_ent_d = 1'b0;
            state_d = StWaitB;
          end
`ifdef CALC_BACKSPACE_EN
          else if (is_bksp) a_d = {1'b0, opnd_bs};
`endif
        end
        StWaitB: begin
          if (is_digit) begin
            if (digit_ok) begin
              b_d     = opnd_app;
              b_ent_d = 1'b1;
            end
          end else if (is_op) begin
            if (!b_ent_q) op_d = op_key;
          end else if (is_eq) begin
            mcand_d  = {27'd0, a_mag};
            mplier_d = b_q;
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = StCalc;
          end
`ifdef CALC_BACKSPACE_EN
          else if (is_bksp) b_d = opnd_bs;
`endif
        end
        StCalc: begin
          if (op_q == OpMul) begin
            prod_d   = prod_nx;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
          end
          if (calc_done) begin
            if (calc_ok) begin
              a_d     = calc_val;
              b_d     = '0;
              b_ent_d = 1'b0;
              state_d = StResult;
            end else begin
              state_d = StError;
            end
          end
        end
        StResult: begin
          if (is_digit) begin
            a_d     = {24'd0, cmd};
            b_d     = '0;
            b_ent_d = 1'b0;
            state_d = StWaitA;
          end else if (is_op) begin
            op_d    = op_key;
            b_d     = '0;
            b_ent_d = 1'b0;
            state_d = StWaitB;
          end
        end
        StError: ;
        default: state_d = StWaitA;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StWaitA;
      cmd_q    <= 4'hF;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OpAdd;
      b_ent_q  <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      b_ent_q  <= b_ent_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign EA = state_q;
  assign PE = state_d;

  always_comb begin
    status = 2'b00;
    if (state_q == StCalc)       status = 2'b01;
    else if (state_q == StError) status = 2'b10;
  end

  function automatic logic [6:0] seg_font(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // B is shown once its first digit arrives; CALC keeps showing whatever WAIT_B showed.
  logic        show_b, disp_neg, minus_done;
  logic [26:0] disp_rem;

  assign show_b   = b_ent_q && ((state_q == StWaitB) || (state_q == StCalc));
  assign disp_neg = !show_b && a_q[27];

  always_comb begin
    displays   = '0;
    minus_done = 1'b0;
    disp_rem   = show_b ? b_q : a_mag;
    if (state_q == StError) begin
      displays[0] = SegE;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if ((i == 0) || (disp_rem != '0)) begin
          displays[i] = seg_font(4'(disp_rem % 27'd10));
        end else if (disp_neg && !minus_done) begin
          displays[i] = SegMinus;
          minus_done  = 1'b1;
        end
        disp_rem = disp_rem / 27'd10;
      end
    end
  end

endmodule

// File: tb/tb_calc_top.sv
// tb_calc_top: self-checking bench for calc_top (table vectors, corner sequences, random keys
// against a behavioural calculator model).
module tb_calc_top;

  typedef logic [7:0][6:0] disp_t;
  typedef struct {
    logic [3:0] key;
    int         hold;
    int         st;
    longint     val;
  } vec_t;

  logic       clock, reset;
  logic [3:0] cmd;
  disp_t      displays;
  logic [1:0] status;
  logic [2:0] EA, PE;

  int checks, errors;

  // Behavioural model: states 0 WAIT_A, 1 WAIT_B, 3 RESULT, 4 ERROR (CALC resolved instantly).
  int         m_state, m_op;
  longint     m_a, m_b;
  bit         m_bent;
  logic [3:0] m_prev;

  logic [6:0] font_t [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  vec_t vecs [$];

  calc_top dut (
    .clock   (clock),
    .reset   (reset),
    .cmd     (cmd),
    .displays(displays),
    .status  (status),
    .EA      (EA),
    .PE      (PE)
  );

  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic disp_t exp_disp(input int st, input longint val);
    disp_t d;
    string s;
    int    n, c;
    d = '0;
    if (st == 4) begin
      d[0] = 7'b1111001;
      return d;
    end
    s = $sformatf("%0d", val);
    n = s.len();
    for (int i = 0; i < n && i < 8; i++) begin
      c = int'(s[n-1-i]);
      if (c == 45) d[i] = 7'b1000000;
      else         d[i] = font_t[c-48];
    end
    return d;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_op = 10; m_a = 0; m_b = 0; m_bent = 0; m_prev = 4'hF;
  endfunction

  function automatic void model_key(input logic [3:0] k);
    int     kv;
    longint cur, r;
    kv = int'(k);
    if (k == m_prev) return;
    m_prev = k;
    if (kv == 13) begin
      model_reset();
      m_prev = k;
      return;
    end
    if (m_state == 0 || m_state == 1) begin
      cur = (m_state == 0) ? m_a : m_b;
      if (kv <= 9) begin
        if (cur < 10000000 && !(kv == 0 && cur == 0)) begin
          cur = cur * 10 + kv;
          if (m_state == 1) m_bent = 1;
        end
      end else if (kv >= 10 && kv <= 12) begin
        if (m_state == 0) begin
          m_op = kv; m_b = 0; m_bent = 0; m_state = 1;
          return;
        end
        if (!m_bent) m_op = kv;
      end else if (kv == 14 && m_state == 1) begin
        if (m_op == 10)      r = m_a + m_b;
        else if (m_op == 11) r = m_a - m_b;
        else                 r = m_a * m_b;
        if (r >= -9999999 && r <= 99999999) begin
          m_a = r; m_b = 0; m_bent = 0; m_state = 3;
        end else begin
          m_state = 4;
        end
        return;
      end else if (kv == 15) begin
`ifdef CALC_BACKSPACE_EN
        cur = cur / 10;
`endif
      end
      if (m_state == 0) m_a = cur;
      else              m_b = cur;
    end else if (m_state == 3) begin
      if (kv <= 9) begin
        m_a = kv; m_b = 0; m_bent = 0; m_state = 0;
      end else if (kv >= 10 && kv <= 12) begin
        m_op = kv; m_b = 0; m_bent = 0; m_state = 1;
      end
    end
  endfunction

  // Called at a falling edge; rides out any CALC phase before the hold completes.
  task automatic press(input logic [3:0] k, input int hold);
    int n;
    cmd = k;
    model_key(k);
    @(negedge clock);
    if (EA == 3'd2) begin
      check("calc_status_busy", 64'(status), 64'd1);
      n = 1;
      while (EA == 3'd2 && n < 40) begin
        @(negedge clock);
        n++;
      end
      check("calc_within_32", 64'(n <= 32), 64'd1);
    end
    repeat (hold - 1) @(negedge clock);
  endtask

  task automatic do_reset();
    cmd   = 4'hF;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    longint v;
    v = (m_state == 1 && m_bent) ? m_b : m_a;
    check({tag, "_ea"}, 64'(EA), 64'(m_state));
    check({tag, "_pe"}, 64'(PE), 64'(m_state));
    check({tag, "_status"}, 64'(status), (m_state == 4) ? 64'd2 : 64'd0);
    check({tag, "_disp"}, 64'(displays), 64'(exp_disp(m_state, v)));
  endtask

  function automatic void add_vec(input logic [3:0] k, input int h, input int s, input longint v);
    vec_t e;
    e.key = k; e.hold = h; e.st = s; e.val = v;
    vecs.push_back(e);
  endfunction

  int         rnd, n;
  logic [3:0] k;

  initial begin
    clock = 1'b0; reset = 1'b1; cmd = 4'hF; checks = 0; errors = 0;
    model_reset();

    // Asynchronous reset, observed before any clock edge reaches the design.
    #2 reset = 1'b0;
    #1;
    check("reset_ea", 64'(EA), 64'd0);
    check("reset_status", 64'(status), 64'd0);
    check("reset_disp", 64'(displays), 64'h3F);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    add_vec(4'd1, 10, 0, 1);         add_vec(4'd2, 10, 0, 12);
    add_vec(4'd12, 10, 1, 12);       add_vec(4'd3, 10, 1, 3);
    add_vec(4'd14, 10, 3, 36);       add_vec(4'd13, 3, 0, 0);
    add_vec(4'd5, 3, 0, 5);          add_vec(4'd11, 3, 1, 5);
    add_vec(4'd9, 3, 1, 9);          add_vec(4'd14, 3, 3, -4);
    add_vec(4'd10, 3, 1, -4);        add_vec(4'd6, 3, 1, 6);
    add_vec(4'd14, 3, 3, 2);         add_vec(4'd8, 3, 0, 8);
    add_vec(4'd14, 3, 0, 8);         add_vec(4'd8, 3, 0, 88);
    add_vec(4'd13, 3, 0, 0);         add_vec(4'd0, 3, 0, 0);
    add_vec(4'd7, 3, 0, 7);          add_vec(4'd10, 3, 1, 7);
    add_vec(4'd11, 3, 1, 7);         add_vec(4'd2, 3, 1, 2);
    add_vec(4'd10, 3, 1, 2);         add_vec(4'd14, 3, 3, 5);
    add_vec(4'd12, 3, 1, 5);         add_vec(4'd0, 3, 1, 5);
    add_vec(4'd11, 3, 1, 5);         add_vec(4'd3, 3, 1, 3);
    add_vec(4'd0, 3, 1, 30);         add_vec(4'd14, 3, 3, -25);
    add_vec(4'd12, 3, 1, -25);       add_vec(4'd4, 3, 1, 4);
    add_vec(4'd14, 3, 3, -100);      add_vec(4'd12, 3, 1, -100);
    add_vec(4'd9, 3, 1, 9);          add_vec(4'd8, 3, 1, 98);
    add_vec(4'd7, 3, 1, 987);        add_vec(4'd6, 3, 1, 9876);
    add_vec(4'd5, 3, 1, 98765);      add_vec(4'd14, 3, 3, -9876500);
    add_vec(4'd12, 3, 1, -9876500);  add_vec(4'd2, 3, 1, 2);
    add_vec(4'd14, 3, 4, 0);         add_vec(4'd12, 3, 4, 0);
    add_vec(4'd13, 3, 0, 0);

    foreach (vecs[i]) begin
      press(vecs[i].key, vecs[i].hold);
      check($sformatf("vec%0d_ea", i), 64'(EA), 64'(vecs[i].st));
      check($sformatf("vec%0d_status", i), 64'(status), (vecs[i].st == 4) ? 64'd2 : 64'd0);
      check($sformatf("vec%0d_disp", i), 64'(displays), 64'(exp_disp(vecs[i].st, vecs[i].val)));
    end

    // Reset mid-entry takes effect without a clock edge.
    press(4'd5, 2);
    #2 reset = 1'b0;
    #1;
    check("async_reset_ea", 64'(EA), 64'd0);
    check("async_reset_disp", 64'(displays), 64'(exp_disp(0, 0)));
    cmd = 4'hF;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    model_reset();

    // A held key acts once.
    press(4'd7, 20);
    check("held_key_disp", 64'(displays), 64'(exp_disp(0, 7)));

    // Ninth digit is dropped.
    do_reset();
    for (int d = 1; d <= 9; d++) press(4'(d), 2);
    check("nine_digit_disp", 64'(displays), 64'(exp_disp(0, 12345678)));

    // Overflow to ERROR; only clear leaves it.
    do_reset();
    repeat (8) begin
      press(4'd9, 2);
      press(4'd14, 2);
    end
    check("eight_nines_disp", 64'(displays), 64'(exp_disp(0, 99999999)));
    press(4'd10, 2); press(4'd1, 2); press(4'd14, 2);
    check("overflow_ea", 64'(EA), 64'd4);
    check("overflow_status", 64'(status), 64'd2);
    check("overflow_disp", 64'(displays), 64'(exp_disp(4, 0)));
    press(4'd11, 2); press(4'd3, 2);
    check("error_holds_ea", 64'(EA), 64'd4);
    press(4'd13, 2);
    check("error_clear_ea", 64'(EA), 64'd0);
    check("error_clear_disp", 64'(displays), 64'(exp_disp(0, 0)));

    // Keys arriving during CALC are ignored.
    do_reset();
    press(4'd2, 2); press(4'd12, 2); press(4'd3, 2);
    cmd = 4'd14;
    @(negedge clock);
    check("calc_entered", 64'(EA), 64'd2);
    cmd = 4'd13;
    @(negedge clock);
    cmd = 4'd5;
    n = 0;
    while (EA == 3'd2 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("calc_ignore_ea", 64'(EA), 64'd3);
    check("calc_ignore_disp", 64'(displays), 64'(exp_disp(3, 6)));

    // Reset during CALC leaves nothing behind.
    do_reset();
    press(4'd7, 2); press(4'd12, 2); press(4'd8, 2);
    cmd = 4'd14;
    repeat (3) @(negedge clock);
    check("abort_in_calc", 64'(EA), 64'd2);
    #2 reset = 1'b0;
    #1;
    check("abort_ea", 64'(EA), 64'd0);
    check("abort_status", 64'(status), 64'd0);
    cmd = 4'hF;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    model_reset();
    repeat (40) @(negedge clock);
    check("abort_no_residue_ea", 64'(EA), 64'd0);
    check("abort_no_residue_disp", 64'(displays), 64'(exp_disp(0, 0)));

    // Backspace build option.
    do_reset();
    press(4'd4, 2); press(4'd5, 2); press(4'd15, 2);
`ifdef CALC_BACKSPACE_EN
    check("backspace_disp", 64'(displays), 64'(exp_disp(0, 4)));
`else
    check("backspace_disp", 64'(displays), 64'(exp_disp(0, 45)));
`endif

    // Random keys against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom_range(0, 99);
      if (rnd < 55)      k = 4'($urandom_range(0, 9));
      else if (rnd < 75) k = 4'($urandom_range(10, 12));
      else if (rnd < 90) k = 4'd14;
      else if (rnd < 95) k = 4'd13;
      else               k = 4'd15;
      press(k, $urandom_range(1, 3));
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_top.md
CALC_TOP -- requirements
Module: calc_top

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset; ports `clock` and `reset` use the codebase names, and `reset`=0 asserts.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces reset state.
REQ-004 cmd  input  4  key code: 0-9 digit; 1010 add; 1011 sub; 1100 mul; 1101 clear; 1110 equals; 1111 backspace.
REQ-005 displays  output  array [7:0] of 7 bits  seven-segment digits, active-high, bit order gfedcba; displays[0] is least significant.
REQ-006 status  output  2  00 ready; 01 busy; 10 error.
REQ-007 EA  output  3  current FSM state.
REQ-008 PE  output  3  next FSM state, combinational.

Function
REQ-009 cmd SHALL be registered every clock; a command SHALL be accepted only in the cycle its value differs from the previous sample, so a held key acts once.
REQ-010 States SHALL be encoded as WAIT_A=0, WAIT_B=1, CALC=2, RESULT=3, ERROR=4; codes 5-7 SHALL go to WAIT_A.
REQ-011 Digit in WAIT_A or WAIT_B SHALL append to the active operand (A or B) as the new least-significant decimal digit.
REQ-012 A digit SHALL be ignored when the operand already has 8 digits, and a 0 SHALL be ignored when the operand is 0.
REQ-013 Operator in WAIT_A SHALL latch the operator and go to WAIT_B with B=0.
REQ-014 Operator in WAIT_B before any B digit SHALL replace the latched operator.
REQ-015 Equals in WAIT_B SHALL go to CALC; an unentered B counts as 0.
REQ-016 Add and sub SHALL finish in 1 CALC cycle.
REQ-017 Mul SHALL use iterative shift-add, 1 bit per clock, finishing within 32 CALC cycles.
REQ-018 status SHALL be 01 throughout CALC, and commands arriving during CALC SHALL be ignored.
REQ-019 At the end of CALC, a result in the range -9,999,999..99,999,999 SHALL go to RESULT with status 00.
REQ-020 At the end of CALC, a result outside that range SHALL go to ERROR with status 10.
REQ-021 In RESULT, a digit SHALL start a new A holding that digit, in WAIT_A.
REQ-022 In RESULT, an operator SHALL chain, using the result as A, and go to WAIT_B.
REQ-023 In RESULT, equals SHALL be ignored.
REQ-024 In ERROR, only clear (or reset) SHALL be accepted; displays[0] shows "E" and the others are blank.
REQ-025 Clear in any non-CALC state SHALL zero A, B and the operator and go to WAIT_A.
REQ-026 Display source SHALL be A in WAIT_A, A in WAIT_B until the first B digit, then B, and the result in RESULT; the last value is held during CALC.
REQ-027 Numbers SHALL be shown in decimal with leading zeros blanked; the value 0 shows "0" on displays[0].
REQ-028 A negative result SHALL show a minus sign (segment g only) in the display left of its most-significant digit.
REQ-029 Digit font SHALL be the standard one: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, E=1111001; blank=0000000.

Reset
REQ-030 With reset=0, and independent of clock: EA=WAIT_A, A=B=0, operator=add, status=00, displays[0]="0", others blank.
REQ-031 The registered previous-cmd value SHALL reset to 1111.
REQ-032 Reset during CALC SHALL abort the operation with no residual result.

Configuration
REQ-033 Macro CALC_BACKSPACE_EN: when defined, 1111 in WAIT_A/WAIT_B SHALL delete the active operand's least-significant digit (operand/10; deleting the last digit gives 0).
REQ-034 When CALC_BACKSPACE_EN is undefined, 1111 SHALL be ignored everywhere.

Verification
REQ-035 Reset pulse low -> EA=0, status=00, displays[0]=0111111, displays[7:1]=0000000.
REQ-036 Keys 1, 2, mul, 3, equals, each held 10 clocks -> displays show "12", then "3", status=01 during CALC, then "36" with EA=RESULT and status=00 within 32 clocks of equals.
REQ-037 Keys 5, sub, 9, equals -> displays[1]=minus, displays[0]="4", status=00.
REQ-038 Key 9 eight times, add, 1, equals -> EA=ERROR, status=10, "E"; then clear -> WAIT_A showing "0".
REQ-039 Key 7 held 20 clocks -> displays show "7", not "77"; 9-digit entry -> 9th digit ignored.
REQ-040 With CALC_BACKSPACE_EN: keys 4, 5, backspace -> shows "4"; without it -> shows "45".
